// File: rtl/event_timer_core_if.sv
// rtl/event_timer_core_if.sv - CPU write bus and save-state port bundle for event_timer_core
interface event_timer_core_if;
    logic       cpu_ce;
    logic       cpu_rw;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_dat;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_rdat;

    modport master (
        output cpu_ce, cpu_rw, cpu_addr, cpu_dat,
        output ss_act, ss_we, ss_addr,
        input  ss_rdat
    );

    modport slave (
        input  cpu_ce, cpu_rw, cpu_addr, cpu_dat,
        input  ss_act, ss_we, ss_addr,
        output ss_rdat
    );
endinterface

// File: rtl/event_timer_core.sv
// rtl/event_timer_core.sv - serial-loaded register file with preset event timer and save-state access
module event_timer_core #(
    parameter int CNT_W   = 30,
    parameter int DIP_W   = 4,
    parameter int NREG    = 4,
    parameter int TMR_REG = 1,
    parameter int RELOAD  = 0
) (
    input  logic                m2,
    input  logic                map_rst_n,
    event_timer_core_if.slave   bus,
    input  logic [DIP_W-1:0]    dip,
    output logic [5*NREG-1:0]   regs,
    output logic                irq,
    output logic [CNT_W-1:0]    count
);

    localparam logic [7:0]       SLOT_CTL = 8'(NREG);
    localparam logic [7:0]       SLOT_FLG = 8'(NREG + 1);
    localparam int               NB       = (CNT_W + 7) / 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_IRQ  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0]       reg_q [NREG];
    logic [3:0]       buff;
    logic [2:0]       ctr;
    logic             we_st;
    logic             wr_ev;
    logic             hold;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] cnt_ss;

    // A write is only recognised on the first cycle of a CPU write access
    assign wr_ev  = !bus.cpu_ce && !bus.cpu_rw && we_st;
    assign hold   = reg_q[TMR_REG][4];
    assign preset = {1'b0, dip, {(CNT_W-1-DIP_W){1'b0}}};

    // Flatten the register array onto the output bus
    always_comb begin
        regs = '0;
        for (int i = 0; i < NREG; i++) begin
            regs[5*i +: 5] = reg_q[i];
        end
    end

    // Counter image after a save-state byte write into one of the count slots
    always_comb begin
        cnt_ss = count;
        for (int b = 0; b < CNT_W; b++) begin
            if (bus.ss_addr == 8'(NREG + 2 + b / 8)) begin
                cnt_ss[b] = bus.cpu_dat[b % 8];
            end
        end
    end

    // Save-state readback, unused slots float high
    always_comb begin
        bus.ss_rdat = 8'hFF;
        for (int i = 0; i < NREG; i++) begin
            if (bus.ss_addr == 8'(i)) begin
                bus.ss_rdat = {3'b000, reg_q[i]};
            end
        end
        if (bus.ss_addr == SLOT_CTL) begin
            bus.ss_rdat = {1'b0, ctr, buff};
        end
        if (bus.ss_addr == SLOT_FLG) begin
            bus.ss_rdat = {6'b000000, we_st, irq};
        end
        for (int k = 0; k < NB; k++) begin
            if (bus.ss_addr == 8'(NREG + 2 + k)) begin
                bus.ss_rdat = 8'h00;
            end
        end
        for (int b = 0; b < CNT_W; b++) begin
            if (bus.ss_addr == 8'(NREG + 2 + b / 8)) begin
                bus.ss_rdat[b % 8] = count[b];
            end
        end
    end

    // Serial write decoder: shift four bits into buff, the fifth commits a register
    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= (i == 0) ? 5'b01100 : 5'b00000;
            end
            buff  <= 4'd0;
            ctr   <= 3'd0;
            we_st <= 1'b1;
        end else if (bus.ss_act) begin
            if (bus.ss_we) begin
                for (int i = 0; i < NREG; i++) begin
                    if (bus.ss_addr == 8'(i)) begin
                        reg_q[i] <= bus.cpu_dat[4:0];
                    end
                end
                if (bus.ss_addr == SLOT_CTL) begin
                    ctr  <= bus.cpu_dat[6:4];
                    buff <= bus.cpu_dat[3:0];
                end
                if (bus.ss_addr == SLOT_FLG) begin
                    we_st <= bus.cpu_dat[1];
                end
            end
        end else begin
            we_st <= bus.cpu_rw | bus.cpu_ce;
            if (wr_ev) begin
                if (bus.cpu_dat[7]) begin
                    ctr         <= 3'd0;
                    buff        <= 4'd0;
                    reg_q[0][3:2] <= 2'b11;
                end else if (ctr != 3'd4) begin
                    buff <= {bus.cpu_dat[0], buff[3:1]};
                    ctr  <= ctr + 3'd1;
                end else begin
                    for (int i = 0; i < NREG; i++) begin
                        if (bus.cpu_addr == 2'(i)) begin
                            reg_q[i] <= {bus.cpu_dat[0], buff};
                        end
                    end
                    ctr  <= 3'd0;
                    buff <= 4'd0;
                end
            end
        end
    end

    // Timer: held at preset while hold is set, otherwise counts and flags the period end
    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            count <= '0;
            irq   <= 1'b0;
        end else if (bus.ss_act) begin
            if (bus.ss_we) begin
                count <= cnt_ss;
                if (bus.ss_addr == SLOT_FLG) begin
                    irq <= bus.cpu_dat[0];
                end
            end
        end else if (hold) begin
            count <= preset;
            irq   <= 1'b0;
        end else begin
            if (RELOAD != 0 && count == CNT_MAX) begin
                count <= preset;
            end else begin
                count <= count + CNT_ONE;
            end
            if (count == CNT_IRQ) begin
                irq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_timer_core.sv
// tb/tb_event_timer_core.sv - directed self-checking bench for event_timer_core
module tb_event_timer_core;

    logic        m2 = 1'b1;
    logic        map_rst_n;
    logic [3:0]  dip;
    logic [19:0] regs_a, regs_b, regs_c;
    logic        irq_a, irq_b, irq_c;
    logic [7:0]  count_a, count_b;
    logic [29:0] count_c;
    int          n_cmp = 0;
    int          n_err = 0;

    event_timer_core_if bus_a ();
    event_timer_core_if bus_b ();
    event_timer_core_if bus_c ();

    assign bus_b.cpu_ce   = bus_a.cpu_ce;
    assign bus_b.cpu_rw   = bus_a.cpu_rw;
    assign bus_b.cpu_addr = bus_a.cpu_addr;
    assign bus_b.cpu_dat  = bus_a.cpu_dat;
    assign bus_b.ss_act   = bus_a.ss_act;
    assign bus_b.ss_we    = bus_a.ss_we;
    assign bus_b.ss_addr  = bus_a.ss_addr;
    assign bus_c.cpu_ce   = bus_a.cpu_ce;
    assign bus_c.cpu_rw   = bus_a.cpu_rw;
    assign bus_c.cpu_addr = bus_a.cpu_addr;
    assign bus_c.cpu_dat  = bus_a.cpu_dat;
    assign bus_c.ss_act   = bus_a.ss_act;
    assign bus_c.ss_we    = bus_a.ss_we;
    assign bus_c.ss_addr  = bus_a.ss_addr;

    event_timer_core #(.CNT_W(8), .DIP_W(4), .NREG(4), .TMR_REG(1), .RELOAD(0)) dut_a (
        .m2(m2), .map_rst_n(map_rst_n), .bus(bus_a.slave), .dip(dip),
        .regs(regs_a), .irq(irq_a), .count(count_a)
    );

    event_timer_core #(.CNT_W(8), .DIP_W(4), .NREG(4), .TMR_REG(1), .RELOAD(1)) dut_b (
        .m2(m2), .map_rst_n(map_rst_n), .bus(bus_b.slave), .dip(dip),
        .regs(regs_b), .irq(irq_b), .count(count_b)
    );

    event_timer_core dut_c (
        .m2(m2), .map_rst_n(map_rst_n), .bus(bus_c.slave), .dip(dip),
        .regs(regs_c), .irq(irq_c), .count(count_c)
    );

    always #5 m2 = ~m2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge m2);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        bus_a.cpu_ce   = 1'b0;
        bus_a.cpu_rw   = 1'b0;
        bus_a.cpu_addr = a;
        bus_a.cpu_dat  = d;
        step(1);
        bus_a.cpu_ce   = 1'b1;
        bus_a.cpu_rw   = 1'b1;
        step(1);
    endtask

    task automatic load5(input logic [1:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            cpu_wr(a, {7'b0000000, v[i]});
        end
    endtask

    task automatic ss_peek(input logic [7:0] a);
        bus_a.ss_addr = a;
        #1;
    endtask

    initial begin
        map_rst_n      = 1'b0;
        dip            = 4'b1100;
        bus_a.cpu_ce   = 1'b1;
        bus_a.cpu_rw   = 1'b1;
        bus_a.cpu_addr = 2'd0;
        bus_a.cpu_dat  = 8'h00;
        bus_a.ss_act   = 1'b0;
        bus_a.ss_we    = 1'b0;
        bus_a.ss_addr  = 8'h00;
        step(2);

        check("rst_regs", regs_a, 32'h0000C);
        check("rst_count", count_a, 32'h0);
        check("rst_irq", irq_a, 32'h0);
        ss_peek(8'd4);
        check("rst_ctl", bus_a.ss_rdat, 32'h00);
        ss_peek(8'd5);
        check("rst_flg", bus_a.ss_rdat, 32'h02);

        map_rst_n = 1'b1;
        // d0 sequence 1,0,1,1,0 into register 2
        cpu_wr(2'd2, 8'h01);
        cpu_wr(2'd2, 8'h00);
        cpu_wr(2'd2, 8'h01);
        cpu_wr(2'd2, 8'h01);
        cpu_wr(2'd2, 8'h00);
        check("reg2_load", regs_a, 32'h0340C);
        ss_peek(8'd4);
        check("ctr_after_load", bus_a.ss_rdat, 32'h00);
        ss_peek(8'd2);
        check("ss_reg2", bus_a.ss_rdat, 32'h0D);
        check("count_free_a", count_a, 32'h0A);
        check("count_free_c", count_c, 32'h0A);

        // reg0 = 10001 so the reset command's effect on [3:2] is visible
        load5(2'd0, 5'b10001);
        check("reg0_load", regs_a, 32'h03411);

        // Same write held across two edges: only the first shifts
        bus_a.cpu_ce = 1'b0; bus_a.cpu_rw = 1'b0; bus_a.cpu_addr = 2'd3; bus_a.cpu_dat = 8'h01;
        step(2);
        bus_a.cpu_ce = 1'b1; bus_a.cpu_rw = 1'b1;
        step(1);
        ss_peek(8'd4);
        check("adjacent_write", bus_a.ss_rdat, 32'h18);

        cpu_wr(2'd3, 8'h00);
        cpu_wr(2'd3, 8'h01);
        ss_peek(8'd4);
        check("three_bits", bus_a.ss_rdat, 32'h3A);
        cpu_wr(2'd3, 8'h80);
        ss_peek(8'd4);
        check("cmd_clear_ctl", bus_a.ss_rdat, 32'h00);
        check("cmd_reg0", regs_a, 32'h0341D);
        check("cmd_reg0_c", regs_c, 32'h0341D);

        // Hold: count forced to preset
        load5(2'd1, 5'b10000);
        check("hold_regs", regs_a, 32'h0361D);
        check("hold_count_a", count_a, 32'h60);
        check("hold_count_b", count_b, 32'h60);
        check("hold_count_c", count_c, 32'h18000000);
        check("hold_irq", irq_a, 32'h0);

        // Release hold; the idle cycle of the last access is the first running edge
        load5(2'd1, 5'b00000);
        check("run_first", count_a, 32'h61);
        step(157);
        check("pre_irq_count", count_a, 32'hFE);
        check("pre_irq", irq_a, 32'h0);
        step(1);
        check("irq_edge_a", irq_a, 32'h1);
        check("irq_edge_count", count_a, 32'hFF);
        check("irq_edge_b", irq_b, 32'h1);
        check("irq_edge_c_count", count_c, 32'h1800009F);
        check("irq_edge_c", irq_c, 32'h0);
        step(1);
        check("wrap_count_a", count_a, 32'h00);
        check("sticky_irq_a", irq_a, 32'h1);
        check("reload_count_b", count_b, 32'h60);
        check("reload_irq_b", irq_b, 32'h1);

        // Set hold again; irq drops on the edge after the load
        for (int i = 0; i < 4; i++) cpu_wr(2'd1, 8'h00);
        bus_a.cpu_ce = 1'b0; bus_a.cpu_rw = 1'b0; bus_a.cpu_dat = 8'h01;
        step(1);
        check("load_edge_irq_b", irq_b, 32'h1);
        check("load_edge_count_b", count_b, 32'h69);
        bus_a.cpu_ce = 1'b1; bus_a.cpu_rw = 1'b1;
        step(1);
        check("hold_irq_b", irq_b, 32'h0);
        check("hold_irq_a", irq_a, 32'h0);
        check("hold_again_b", count_b, 32'h60);

        // Reset mid-count with two bits shifted in
        load5(2'd1, 5'b00000);
        cpu_wr(2'd3, 8'h01);
        cpu_wr(2'd3, 8'h01);
        check("mid_count", count_a, 32'h65);
        ss_peek(8'd4);
        check("two_bits", bus_a.ss_rdat, 32'h2C);
        map_rst_n = 1'b0;
        #1;
        check("mid_rst_regs", regs_a, 32'h0000C);
        check("mid_rst_count", count_a, 32'h0);
        check("mid_rst_count_c", count_c, 32'h0);
        check("mid_rst_irq", irq_a, 32'h0);
        check("mid_rst_ctl", bus_a.ss_rdat, 32'h00);
        ss_peek(8'd5);
        check("mid_rst_flg", bus_a.ss_rdat, 32'h02);

        // Save-state write and readback of the count bytes
        step(1);
        map_rst_n     = 1'b1;
        bus_a.ss_act  = 1'b1;
        bus_a.ss_we   = 1'b1;
        bus_a.ss_addr = 8'd6;
        bus_a.cpu_dat = 8'hA5;
        step(1);
        check("ss_wr_count", count_a, 32'hA5);
        bus_a.ss_addr = 8'd9;
        bus_a.cpu_dat = 8'hFF;
        step(1);
        bus_a.ss_we = 1'b0;
        check("ss_wr_count_c", count_c, 32'h3F0000A5);
        check("ss_keep_a", count_a, 32'hA5);
        ss_peek(8'd6);
        check("ss_rd_a", bus_a.ss_rdat, 32'hA5);
        check("ss_rd_b", bus_b.ss_rdat, 32'hA5);
        ss_peek(8'd9);
        check("ss_rd_c_top", bus_c.ss_rdat, 32'h3F);
        check("ss_rd_unused", bus_a.ss_rdat, 32'hFF);

        // CPU writes are ignored while save-state is active
        bus_a.cpu_ce = 1'b0; bus_a.cpu_rw = 1'b0; bus_a.cpu_dat = 8'h01;
        step(1);
        bus_a.cpu_ce = 1'b1; bus_a.cpu_rw = 1'b1;
        ss_peek(8'd4);
        check("ss_block_ctl", bus_a.ss_rdat, 32'h00);
        check("ss_block_count", count_a, 32'hA5);
        bus_a.ss_act = 1'b0;
        step(1);
        check("resume_count", count_a, 32'hA6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/event_timer_core.md
EVENT_TIMER_CORE -- requirements
Module: event_timer_core

Interface
REQ-001 SHALL have parameter CNT_W, default 30, timer counter width; legal range DIP_W+2..32.
REQ-002 SHALL have parameter DIP_W, default 4, preset switch width.
REQ-003 SHALL have parameter NREG, default 4, serial register count; legal range 1..4.
REQ-004 SHALL have parameter TMR_REG, default 1, index of the register holding timer control; must be < NREG.
REQ-005 SHALL have parameter RELOAD, default 0; 0 = free-run wrap, 1 = auto-reload at terminal count.
REQ-006 SHALL have port m2  in  1  system clock; all state updates on falling edge.
REQ-007 SHALL have port map_rst_n  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port cpu_ce  in  1  low = CPU access to $8000-$FFFF.
REQ-009 SHALL have port cpu_rw  in  1  high = read, low = write.
REQ-010 SHALL have port cpu_addr  in  2  CPU A14:A13.
REQ-011 SHALL have port cpu_dat  in  8  CPU data bus.
REQ-012 SHALL have port dip  in  DIP_W  timer preset switches.
REQ-013 SHALL have port regs  out  5*NREG  flat register file; reg i at bits [5i+4:5i].
REQ-014 SHALL have port irq  out  1  timer interrupt, active-high, sticky.
REQ-015 SHALL have port count  out  CNT_W  live counter value.
REQ-016 SHALL have ports ss_act in 1, ss_we in 1, ss_addr in 8, ss_rdat out 8: save-state access.

Function
REQ-017 SHALL register we_st <= cpu_rw|cpu_ce every edge; a write event is cpu_ce=0 & cpu_rw=0 & we_st=1, giving one write per CPU access, and a write in the immediately following cycle SHALL be ignored.
REQ-018 SHALL, on a write event with cpu_dat[7]=1, clear ctr and buff and set reg0[3:2]=2'b11; this takes priority over a pending 5th bit.
REQ-019 SHALL, on a write event with cpu_dat[7]=0 and ctr<4, set buff <= {cpu_dat[0], buff[3:1]} and ctr <= ctr+1.
REQ-020 SHALL, on a write event with cpu_dat[7]=0 and ctr=4, load reg[cpu_addr] <= {cpu_dat[0], buff}, clear ctr and buff; index >= NREG is discarded, with ctr and buff still cleared.
REQ-021 SHALL treat bit 4 of reg[TMR_REG] as hold; timer logic uses the registered value, so a new hold takes effect on the edge after the load.
REQ-022 SHALL, while hold=1, force count <= preset = {1'b0, dip, CNT_W-1-DIP_W zeros} and irq <= 0 every edge.
REQ-023 SHALL, while hold=0, increment count by 1 each edge, modulo 2^CNT_W.
REQ-024 SHALL set irq <= 1 on the edge where hold=0 and count = 2^CNT_W-2; irq stays set until hold=1 or reset.
REQ-025 SHALL, with RELOAD=1 and count = all-ones, load preset instead of wrapping to 0; irq is then re-asserted on every period, remaining high.
REQ-026 SHALL, while ss_act=1, suspend all write decode and timer updates, holding state.
REQ-027 SHALL, while ss_act=1 and ss_we=1, write cpu_dat to save-state slot ss_addr at the edge.
REQ-028 SHALL use save-state slots: 0..NREG-1 = regs, zero-extended; NREG = {ctr[2:0], buff[3:0]}, zero-extended; NREG+1 = {we_st, irq}; NREG+2 onward = count bytes, little-endian, upper bits zero.
REQ-029 SHALL return 8'hFF on ss_rdat for unused slots, and SHALL drive ss_rdat combinationally.

Reset
REQ-030 SHALL, on map_rst_n=0, immediately set reg0=5'b01100, other regs=0, buff=0, ctr=0, we_st=1, count=0, irq=0, including mid-sequence and during ss_act.
REQ-031 SHALL resume operation on the first falling edge of m2 after map_rst_n rises; a write in progress at reset is lost.

Verification
REQ-032 SHALL cover: CNT_W=8, DIP_W=4, dip=4'b1100, hold set then cleared -> count=8'h60 while held; irq rises on the 159th edge with hold=0.
REQ-033 SHALL cover: writes of d0 = 1,0,1,1,0 to A14:A13=2, spaced 2 cycles apart -> reg2=5'b01101, ctr=0.
REQ-034 SHALL cover: three d0 bits, then a write of 8'h80 -> ctr=0, buff=0, reg0[3:2]=2'b11, other reg0 bits unchanged.
REQ-035 SHALL cover: two write events in adjacent cycles -> only the first shifts; ctr increments by 1.
REQ-036 SHALL cover: RELOAD=1, CNT_W=8, preset 8'h60 -> count goes 8'hFF to 8'h60, irq stays 1; set hold -> irq=0 on the next edge.
REQ-037 SHALL cover: map_rst_n pulsed low mid-count and after 2 shifted bits -> all REQ-030 values immediately; save-state write then read of slot NREG+2 returns the written byte.
